// File: rtl/sync_fifo_multi_input_if.sv
`default_nettype none
// ============================================================================
// sync_fifo_multi_input_if : multi-lane write / single-read FIFO bus
// Rev 1.0
// ============================================================================
interface sync_fifo_multi_input_if #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_WR    = 2
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR*DATAWIDTH-1:0] wr_data;
  logic                        rd_en;
  logic [DATAWIDTH-1:0]        rd_data;
  logic                        rd_valid;
  logic                        full;
  logic                        empty;
  logic [PW-1:0]               count;
  logic [PW-1:0]               free_slots;
  logic                        wr_overflow;
  logic                        rd_underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, free_slots, wr_overflow, rd_underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, free_slots, wr_overflow, rd_underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_multi_input.sv
`default_nettype none
// ============================================================================
// sync_fifo_multi_input : FIFO with NUM_WR compacted write lanes, one read port
// Rev 1.0
// ============================================================================
module sync_fifo_multi_input #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_WR    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sync_fifo_multi_input_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        count_q, count_d;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_overflow_q, wr_overflow_d;
  logic                 rd_underflow_q, rd_underflow_d;

  logic [DATAWIDTH-1:0] lane_data [NUM_WR];
  logic [AW-1:0]        lane_off  [NUM_WR];
  logic [AW-1:0]        lane_addr [NUM_WR];
  logic [PW-1:0]        n_wr;
  logic [PW-1:0]        free_slots;
  logic                 empty;
  logic                 wr_accept;
  logic                 rd_do;

  for (genvar g = 0; g < NUM_WR; g++) begin : g_lane
    assign lane_data[g] = bus.wr_data[g*DATAWIDTH +: DATAWIDTH];
  end

  assign empty      = (count_q == '0);
  assign free_slots = DEPTH_P - count_q;

  // Each enabled lane lands at wr_ptr plus the number of enabled lanes below it.
  always_comb begin
    n_wr = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      lane_off[i]  = n_wr[AW-1:0];
      lane_addr[i] = wr_ptr_q[AW-1:0] + n_wr[AW-1:0];
      n_wr         = n_wr + PW'(bus.wr_en[i]);
    end
  end

  // Acceptance uses occupancy at the start of the cycle; a same-cycle read gives no credit.
  assign wr_accept = (n_wr != '0) && (n_wr <= free_slots);
  assign rd_do     = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d       = wr_accept ? (wr_ptr_q + n_wr) : wr_ptr_q;
    rd_ptr_d       = rd_do ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d        = count_q + (wr_accept ? n_wr : '0) - PW'(rd_do);
    rd_data_d      = rd_do ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
    rd_valid_d     = rd_do;
    wr_overflow_d  = (n_wr > free_slots);
    rd_underflow_d = bus.rd_en && empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_accept && bus.wr_en[i]) begin
        mem_q[lane_addr[i]] <= lane_data[i];
      end
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = (count_q == DEPTH_P);
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.free_slots   = free_slots;
  assign bus.wr_overflow  = wr_overflow_q;
  assign bus.rd_underflow = rd_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_multi_input.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_multi_input : scoreboard bench against a queue-based FIFO model
// Rev 1.0
// ============================================================================
module tb_sync_fifo_multi_input;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int NWR = 2;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    int            count;
    logic          ovf;
    logic          udf;
  } st_t;

  logic clk;
  logic rst_n;

  sync_fifo_multi_input_if #(.DATAWIDTH(DW), .DEPTH(DEPTH), .NUM_WR(NWR)) bus ();

  sync_fifo_multi_input #(.DATAWIDTH(DW), .DEPTH(DEPTH), .NUM_WR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_data_q[$];
  st_t           st_q[$];
  logic [DW-1:0] last_rd;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model applies the read against the pre-write state.
  task automatic step(input logic [1:0] we, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic re);
    st_t s;
    int  n;
    int  free;
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = {d1, d0};
    bus.rd_en   = re;
    n    = int'(we[0]) + int'(we[1]);
    free = DEPTH - model.size();
    s.valid = 1'b0;
    s.ovf   = 1'b0;
    s.udf   = 1'b0;
    if (re) begin
      if (model.size() > 0) begin
        last_rd = model.pop_front();
        exp_data_q.push_back(last_rd);
        s.valid = 1'b1;
      end else begin
        s.udf = 1'b1;
      end
    end
    if (n > free) s.ovf = 1'b1;
    else begin
      if (we[0]) model.push_back(d0);
      if (we[1]) model.push_back(d1);
    end
    s.data  = last_rd;
    s.count = model.size();
    st_q.push_back(s);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(2'b00, '0, '0, 1'b0);
  endtask

  task automatic clear_model();
    model.delete();
    exp_data_q.delete();
    st_q.delete();
    last_rd = '0;
  endtask

  // Monitor: per-cycle status checks plus read-data scoreboard on rd_valid.
  initial begin
    st_t s;
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rd_valid === 1'b1) begin
        if (exp_data_q.size() == 0) chk("spurious_rd_valid", 1, 0);
        else begin
          e = exp_data_q.pop_front();
          chk("rd_data_order", int'(bus.rd_data), int'(e));
        end
      end
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("rd_valid", int'(bus.rd_valid), int'(s.valid));
        chk("rd_data_hold", int'(bus.rd_data), int'(s.data));
        chk("count", int'(bus.count), s.count);
        chk("free_slots", int'(bus.free_slots), DEPTH - s.count);
        chk("full", int'(bus.full), int'(s.count == DEPTH));
        chk("empty", int'(bus.empty), int'(s.count == 0));
        chk("wr_overflow", int'(bus.wr_overflow), int'(s.ovf));
        chk("rd_underflow", int'(bus.rd_underflow), int'(s.udf));
        chk("count_le_depth", int'(bus.count <= DEPTH), 1);
      end
    end
  end

  initial begin
    int lvl;
    last_rd     = '0;
    rst_n       = 1'b0;
    bus.wr_en   = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    #12;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_free", int'(bus.free_slots), DEPTH);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_flags", int'({bus.wr_overflow, bus.rd_underflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single lane on lane 1, then read it back.
    step(2'b10, 8'h00, 8'hA5, 1'b0);
    idle(1);
    step(2'b00, '0, '0, 1'b1);
    idle(1);

    // Dual-lane fill and ordered drain with pointer wrap.
    for (int i = 0; i < 4; i++) step(2'b11, DW'(2*i), DW'(2*i+1), 1'b0);
    for (int i = 0; i < 8; i++) step(2'b00, '0, '0, 1'b1);
    idle(1);

    // Fill to 7, reject a two-lane group, then top up with one lane.
    for (int i = 0; i < 3; i++) step(2'b11, DW'(8'h40 + 2*i), DW'(8'h41 + 2*i), 1'b0);
    step(2'b01, 8'h46, '0, 1'b0);
    step(2'b11, 8'h11, 8'h22, 1'b0);
    step(2'b01, 8'h11, '0, 1'b0);
    // Read plus write while full: write rejected, read proceeds.
    step(2'b10, '0, 8'h77, 1'b1);

    // Drain to 3, then simultaneous read and dual write.
    for (int i = 0; i < 4; i++) step(2'b00, '0, '0, 1'b1);
    step(2'b11, 8'hC1, 8'hC2, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b00, '0, '0, 1'b1);
    // Read while empty: underflow, data held.
    step(2'b00, '0, '0, 1'b1);
    step(2'b00, '0, '0, 1'b1);
    idle(1);

    // Reach count 5 then assert reset between edges.
    step(2'b11, 8'h51, 8'h52, 1'b0);
    step(2'b11, 8'h53, 8'h54, 1'b0);
    step(2'b01, 8'h55, '0, 1'b0);
    @(posedge clk);
    #3;
    bus.wr_en = '0;
    bus.rd_en = 1'b0;
    chk("pre_reset_count", int'(bus.count), 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_empty", int'(bus.empty), 1);
    chk("async_rst_rd_valid", int'(bus.rd_valid), 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b01, 8'h3C, '0, 1'b0);
    step(2'b00, '0, '0, 1'b1);
    idle(1);

    // Randomised traffic with alternating fill/drain bias.
    for (int ph = 0; ph < 6; ph++) begin
      lvl = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 250; i++) begin
        step(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom),
             ($urandom_range(0, 99) < lvl));
      end
    end

    for (int i = 0; i < DEPTH + 2; i++) step(2'b00, '0, '0, 1'b1);
    idle(2);
    chk("pending_reads", exp_data_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
